// File: rtl/keypad_scan_pkg.sv
// Shared keypad key codes, debounce state type and small helpers.
// The calculator FSM imports this package too, so key literals exist only here.
package keypad_scan_pkg;

  localparam logic [7:0] KEY_NONE = 8'hFF;
  localparam logic [7:0] KEY_ADD  = 8'hF0;
  localparam logic [7:0] KEY_SUB  = 8'hF1;
  localparam logic [7:0] KEY_MUL  = 8'hF2;
  localparam logic [7:0] KEY_DIV  = 8'hF3;
  localparam logic [7:0] KEY_CLR  = 8'hC0;
  localparam logic [7:0] KEY_EQU  = 8'hE0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } deb_state_t;

  function automatic logic [7:0] key_digit(input logic [3:0] d);
    return {4'h0, d};
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational frame decoder: 16 row/col hits -> key code, plus a flag
// marking frames with exactly one hit (anything else decodes to KEY_NONE).
module keypad_decode
  import keypad_scan_pkg::*;
(
  input  logic [15:0] hits,
  output logic [7:0]  code,
  output logic        single
);

  logic [3:0] idx_s;
  logic [7:0] map_s;

  // Locate the (last) hit and map it row-major onto the keypad legend.
  always_comb begin
    idx_s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        idx_s = 4'(i);
      end else begin
        idx_s = idx_s;
      end
    end
    case (idx_s)
      4'd0:    map_s = key_digit(4'd1);
      4'd1:    map_s = key_digit(4'd2);
      4'd2:    map_s = key_digit(4'd3);
      4'd3:    map_s = KEY_ADD;
      4'd4:    map_s = key_digit(4'd4);
      4'd5:    map_s = key_digit(4'd5);
      4'd6:    map_s = key_digit(4'd6);
      4'd7:    map_s = KEY_SUB;
      4'd8:    map_s = key_digit(4'd7);
      4'd9:    map_s = key_digit(4'd8);
      4'd10:   map_s = key_digit(4'd9);
      4'd11:   map_s = KEY_MUL;
      4'd12:   map_s = KEY_CLR;
      4'd13:   map_s = key_digit(4'd0);
      4'd14:   map_s = KEY_EQU;
      4'd15:   map_s = KEY_DIV;
      default: map_s = KEY_NONE;
    endcase
    single = (popcount16(hits) == 5'd1);
    if (single) begin
      code = map_s;
    end else begin
      code = KEY_NONE;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with frame-level press/release debounce.
// key_code leads pressed by one clock on press and trails it by one on release.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [7:0] key_code,
  output logic       pressed
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DIV_W-1:0] div_r;
  logic [1:0]       row_idx_r;
  logic [3:0]       row_r;
  logic [11:0]      hits_r;
  logic             slot_last_s;
  logic             frame_end_s;
  logic [15:0]      frame_hits_s;
  logic [7:0]       frame_code_s;
  logic             frame_single_s;
  logic             match_s;

  deb_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [7:0]       cand_r, cand_nxt_s;
  logic [7:0]       key_code_r, key_nxt_s;
  logic             pressed_r, pressed_nxt_s;

  assign slot_last_s  = (div_r == DIV_LAST);
  assign frame_end_s  = slot_last_s && (row_idx_r == 2'd3);
  // Row 3 is never stored: its columns are used live on the frame's last clock.
  assign frame_hits_s = {~col, hits_r};
  assign match_s      = frame_single_s && (frame_code_s == cand_r);
  assign cnt_inc_s    = (cnt_r < CNT_MAX) ? (cnt_r + CNT_ONE) : cnt_r;

  keypad_decode u_decode (
    .hits   (frame_hits_s),
    .code   (frame_code_s),
    .single (frame_single_s)
  );

  // Row slot timer, row drive rotation and per-row column capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r     <= '0;
      row_idx_r <= 2'd0;
      row_r     <= 4'b1110;
      hits_r    <= 12'd0;
    end else if (slot_last_s) begin
      div_r     <= '0;
      row_idx_r <= row_idx_r + 2'd1;
      row_r     <= {row_r[2:0], row_r[3]};
      case (row_idx_r)
        2'd0:    hits_r[3:0]  <= ~col;
        2'd1:    hits_r[7:4]  <= ~col;
        2'd2:    hits_r[11:8] <= ~col;
        default: hits_r       <= hits_r;
      endcase
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      cand_r     <= KEY_NONE;
      key_code_r <= KEY_NONE;
      pressed_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      cand_r     <= cand_nxt_s;
      key_code_r <= key_nxt_s;
      pressed_r  <= pressed_nxt_s;
    end
  end

  // Next-state logic; transitions are evaluated only on frame-end clocks.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    cand_nxt_s    = cand_r;
    key_nxt_s     = key_code_r;
    pressed_nxt_s = pressed_r;
    if (frame_end_s) begin
      case (state_r)
        IDLE: begin
          if (frame_single_s) begin
            cand_nxt_s = frame_code_s;
            if (CNT_MAX == CNT_ONE) begin
              state_nxt_s = HELD;
              cnt_nxt_s   = '0;
              key_nxt_s   = frame_code_s;
            end else begin
              state_nxt_s = PRESS_DEB;
              cnt_nxt_s   = CNT_ONE;
            end
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
          end
        end
        PRESS_DEB: begin
          if (match_s) begin
            if (cnt_inc_s == CNT_MAX) begin
              state_nxt_s = HELD;
              cnt_nxt_s   = '0;
              key_nxt_s   = cand_r;
            end else begin
              cnt_nxt_s = cnt_inc_s;
            end
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
            cand_nxt_s  = KEY_NONE;
          end
        end
        HELD: begin
          if (match_s) begin
            state_nxt_s = HELD;
          end else if (CNT_MAX == CNT_ONE) begin
            state_nxt_s   = IDLE;
            cnt_nxt_s     = '0;
            cand_nxt_s    = KEY_NONE;
            pressed_nxt_s = 1'b0;
          end else begin
            state_nxt_s = REL_DEB;
            cnt_nxt_s   = CNT_ONE;
          end
        end
        REL_DEB: begin
          if (match_s) begin
            state_nxt_s = HELD;
            cnt_nxt_s   = '0;
          end else if (cnt_inc_s == CNT_MAX) begin
            state_nxt_s   = IDLE;
            cnt_nxt_s     = '0;
            cand_nxt_s    = KEY_NONE;
            pressed_nxt_s = 1'b0;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          cnt_nxt_s     = '0;
          cand_nxt_s    = KEY_NONE;
          key_nxt_s     = KEY_NONE;
          pressed_nxt_s = 1'b0;
        end
      endcase
    end else begin
      // Outputs trail the state by one clock so key_code brackets pressed.
      pressed_nxt_s = (state_r == HELD) || (state_r == REL_DEB);
      if ((state_r == IDLE) || (state_r == PRESS_DEB)) begin
        key_nxt_s = KEY_NONE;
      end else begin
        key_nxt_s = key_code_r;
      end
    end
  end

  assign row      = row_r;
  assign key_code = key_code_r;
  assign pressed  = pressed_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad model drives col from row,
// and a frame-level debounce model predicts key_code/pressed at each frame end.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [7:0]  key_code;
  logic        pressed;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int acc    = -1;
  int run    = 0;
  int cand   = -1;
  int skip   = 0;

  logic [7:0] code_tab [16] = '{8'h01, 8'h02, 8'h03, 8'hF0,
                                8'h04, 8'h05, 8'h06, 8'hF1,
                                8'h07, 8'h08, 8'h09, 8'hF2,
                                8'hC0, 8'h00, 8'hE0, 8'hF3};

  localparam logic [15:0] K_NONE = 16'h0000;
  localparam logic [15:0] K_5    = 16'h0020;
  localparam logic [15:0] K_7    = 16'h0100;
  localparam logic [15:0] K_CLR  = 16'h1000;
  localparam logic [15:0] K_EQU  = 16'h4000;
  localparam logic [15:0] K_ADD  = 16'h0008;

  always #5 clk = ~clk;

  // Passive keypad: a held key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row[r] == 1'b0 && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  keypad_scan #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .pressed  (pressed)
  );

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_code(input int a);
    if (a < 0) return 8'hFF;
    return code_tab[a];
  endfunction

  // -1 for no key or several keys, else index of the single key.
  function automatic int frame_class(input logic [15:0] k);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  // Frame-level debounce: DEB_CNT (=3) agreeing frames to accept or release.
  task automatic model_step(input int f);
    if (acc < 0) begin
      if (run > 0) begin
        if (f >= 0 && f == cand) run++; else run = 0;
      end else if (f >= 0) begin
        cand = f; run = 1;
      end
      if (run == 3) begin acc = cand; run = 0; end
    end else begin
      if (f != acc) run++; else run = 0;
      if (run == 3) begin acc = -1; run = 0; cand = -1; end
    end
  endtask

  task automatic run_frame(input logic [15:0] k, input bit chk_rows);
    int prev;
    logic [3:0] exp_row;
    keys = k;
    for (int n = 1 + skip; n <= 16; n++) begin
      @(posedge clk); #1;
      if (chk_rows) begin
        exp_row = 4'b0001 << ((n / 4) % 4);
        check8("row", {4'h0, row}, {4'h0, ~exp_row});
      end
    end
    prev = acc;
    model_step(frame_class(k));
    check8("key_code_at_frame_end", key_code, (acc >= 0) ? exp_code(acc) : exp_code(prev));
    check8("pressed_at_frame_end", {7'd0, pressed}, {7'd0, (prev >= 0 && acc >= 0)});
    @(posedge clk); #1;
    check8("key_code_settled", key_code, exp_code(acc));
    check8("pressed_settled", {7'd0, pressed}, {7'd0, (acc >= 0)});
    skip = 1;
  endtask

  task automatic frames(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_frame(k, 1'b0);
  endtask

  initial begin
    logic [15:0] pat;
    int a, b, len;
    rst  = 1'b0;
    keys = K_NONE;
    repeat (3) @(posedge clk);
    #1;
    check8("reset_row", {4'h0, row}, 8'h0E);
    check8("reset_key_code", key_code, 8'hFF);
    check8("reset_pressed", {7'd0, pressed}, 8'h00);
    @(negedge clk) rst = 1'b1;

    // Key 5 held from reset release, row sequence checked in the first frame.
    run_frame(K_5, 1'b1);
    frames(K_5, 3);
    frames(K_NONE, 3);
    // Short press interrupted, then a full press.
    frames(K_5, 2);
    frames(K_NONE, 1);
    frames(K_5, 4);
    // Release with one bounce frame back to 5.
    frames(K_NONE, 1);
    frames(K_5, 1);
    frames(K_NONE, 3);
    // '=' and '+' together, then '+' lifted.
    frames(K_EQU | K_ADD, 4);
    frames(K_EQU, 3);
    // Key-to-key change needs a release then a fresh press.
    frames(K_7, 6);
    frames(K_NONE, 3);

    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case ($urandom_range(0, 4))
        0, 1:    pat = K_NONE;
        2, 3:    pat = 16'h0001 << a;
        default: pat = (16'h0001 << a) | (16'h0001 << b);
      endcase
      len = $urandom_range(1, 4);
      frames(pat, len);
    end
    frames(K_NONE, 4);

    // Reset while Clear is held, then re-debounce with it still held.
    frames(K_CLR, 4);
    #3 rst = 1'b0;
    #1;
    check8("midreset_pressed", {7'd0, pressed}, 8'h00);
    check8("midreset_key_code", key_code, 8'hFF);
    check8("midreset_row", {4'h0, row}, 8'h0E);
    @(negedge clk) rst = 1'b1;
    acc = -1; run = 0; cand = -1; skip = 0;
    frames(K_CLR, 4);
    frames(K_NONE, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
